// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, double-buffered
// per-channel pulse widths, optional per-frame slew limiting.
module servo_pwm_multi #(
    parameter int N_CH      = 4,
    parameter int FRAME_CNT = 240000,
    parameter int MIN_T     = 12000,
    parameter int STEP      = 47,
    parameter int SLEW      = 0,
    parameter int CNT_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_ch,
    input  logic [7:0]       wr_pos,
    input  logic [N_CH-1:0]  ch_en,
    output logic [N_CH-1:0]  srv_o,
    output logic             frame_o
);

    localparam int             DW       = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_V   = CNT_W'(FRAME_CNT - 1);
    localparam logic [CNT_W-1:0] CENTRE_V = CNT_W'(MIN_T + 128 * STEP);
    localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_T);
    localparam logic [CNT_W-1:0] STEP_V   = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] SLEW_T   = CNT_W'(SLEW);
    localparam logic [DW-1:0]    SLEW_V   = DW'(SLEW);
    localparam logic [4:0]       NCH_V    = 5'(N_CH);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tgt_t   [N_CH];
    logic [CNT_W-1:0] act_t   [N_CH];
    logic [CNT_W-1:0] act_nxt [N_CH];
    logic signed [CNT_W:0] diff [N_CH];
    logic [CNT_W:0]   mag     [N_CH];
    logic [N_CH-1:0]  en_act;

    logic             last;
    logic             wr_ok;
    logic [CNT_W-1:0] wr_t;

    assign last  = (cnt == LAST_V);
    assign wr_ok = wr_en && ({1'b0, wr_ch} < NCH_V);
    assign wr_t  = MIN_V + CNT_W'(wr_pos) * STEP_V;

    // Next active width: jump straight to target unless the step exceeds the slew limit.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            diff[i]    = $signed({1'b0, tgt_t[i]}) - $signed({1'b0, act_t[i]});
            mag[i]     = diff[i][CNT_W] ? -diff[i] : diff[i];
            act_nxt[i] = tgt_t[i];
            if (SLEW != 0 && mag[i] > SLEW_V) begin
                act_nxt[i] = diff[i][CNT_W] ? (act_t[i] - SLEW_T) : (act_t[i] + SLEW_T);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            en_act  <= '0;
            srv_o   <= '0;
            frame_o <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                tgt_t[i] <= CENTRE_V;
                act_t[i] <= CENTRE_V;
            end
        end else begin
            cnt     <= last ? '0 : cnt + 1'b1;
            frame_o <= (cnt == '0);
            for (int i = 0; i < N_CH; i++) begin
                // Update reads the old target, so a same-cycle write lands next frame.
                if (wr_ok && wr_ch == 4'(i)) begin
                    tgt_t[i] <= wr_t;
                end
                if (last) begin
                    en_act[i] <= ch_en[i];
                    act_t[i]  <= act_nxt[i];
                end
                srv_o[i] <= en_act[i] & (cnt < act_t[i]);
            end
        end
    end

endmodule
